axi_master: RTL and testbench

// Single-beat AXI initiator; drives the axi_slave port set from a simple command/response interface.

---
 rtl/axi_master.sv | 259 +++++++++++++++++++++++++
 tb/tb_axi_master.sv | 333 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/axi_master.sv
// -----------------------------------------------------------------------------
// axi_master
// Single-beat AXI initiator. Takes one read or write command at a time from a
// valid/ready command port, runs the AW/W/B or AR/R handshakes, and returns
// the result on a held valid/ready response port. A per-transaction watchdog
// aborts a transfer that does not complete within TIMEOUT cycles and flags
// rsp_err.
//
// Ports
//   clk, reset_n                   clock (rising edge), async active-low reset
//   cmd_valid/cmd_ready            command handshake (ready only when idle)
//   cmd_write/addr/wdata/wstrb     command fields, captured on accept
//   rsp_valid/rsp_ready            response handshake (held until consumed)
//   rsp_write/rsp_rdata/rsp_err    response fields
//   aw*, w*, b*                    AXI write address / data / response
//   ar*, r*                        AXI read address / data
// -----------------------------------------------------------------------------
module axi_master #(
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 32,
  parameter int TIMEOUT = 256
) (
  input  logic                clk,
  input  logic                reset_n,
  // command port
  input  logic                cmd_valid,
  output logic                cmd_ready,
  input  logic                cmd_write,
  input  logic [ADDR_W-1:0]   cmd_addr,
  input  logic [DATA_W-1:0]   cmd_wdata,
  input  logic [DATA_W/8-1:0] cmd_wstrb,
  // response port
  output logic                rsp_valid,
  input  logic                rsp_ready,
  output logic                rsp_write,
  output logic [DATA_W-1:0]   rsp_rdata,
  output logic                rsp_err,
  // write address channel
  output logic [ADDR_W-1:0]   awaddr,
  output logic [7:0]          awlen,
  output logic                awvalid,
  input  logic                awready,
  // write data channel
  output logic [DATA_W-1:0]   wdata,
  output logic [DATA_W/8-1:0] wstrb,
  output logic                wvalid,
  input  logic                wready,
  // write response channel
  input  logic                bvalid,
  output logic                bready,
  // read address channel
  output logic [ADDR_W-1:0]   araddr,
  output logic [7:0]          arlen,
  output logic                arvalid,
  input  logic                arready,
  // read data channel
  input  logic [DATA_W-1:0]   rdata,
  input  logic                rvalid,
  output logic                rready
);

  localparam int STRB_W = DATA_W / 8;
  // One spare bit so the counter can never wrap before the abort compare hits.
  localparam int CNT_W = $clog2(TIMEOUT) + 1;
  localparam logic [CNT_W-1:0] WDOG_LAST = CNT_W'(TIMEOUT - 1);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WR   = 2'd1,
    ST_RD   = 2'd2,
    ST_RSP  = 2'd3
  } state_t;

  state_t              state_r,     state_s;
  logic                awvalid_r,   awvalid_s;
  logic                wvalid_r,    wvalid_s;
  logic                bready_r,    bready_s;
  logic                arvalid_r,   arvalid_s;
  logic                rready_r,    rready_s;
  logic [ADDR_W-1:0]   awaddr_r,    awaddr_s;
  logic [DATA_W-1:0]   wdata_r,     wdata_s;
  logic [STRB_W-1:0]   wstrb_r,     wstrb_s;
  logic [ADDR_W-1:0]   araddr_r,    araddr_s;
  logic                rsp_valid_r, rsp_valid_s;
  logic                rsp_write_r, rsp_write_s;
  logic [DATA_W-1:0]   rsp_rdata_r, rsp_rdata_s;
  logic                rsp_err_r,   rsp_err_s;
  logic [CNT_W-1:0]    wdog_r,      wdog_s;
  logic                b_done_s;
  logic                r_done_s;

  // Completion is judged on the registered ready we are presenting this cycle.
  assign b_done_s = bvalid & bready_r;
  assign r_done_s = rvalid & rready_r;

  // State register and all registered outputs.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_r     <= ST_IDLE;
      awvalid_r   <= 1'b0;
      wvalid_r    <= 1'b0;
      bready_r    <= 1'b0;
      arvalid_r   <= 1'b0;
      rready_r    <= 1'b0;
      awaddr_r    <= '0;
      wdata_r     <= '0;
      wstrb_r     <= '0;
      araddr_r    <= '0;
      rsp_valid_r <= 1'b0;
      rsp_write_r <= 1'b0;
      rsp_rdata_r <= '0;
      rsp_err_r   <= 1'b0;
      wdog_r      <= '0;
    end else begin
      state_r     <= state_s;
      awvalid_r   <= awvalid_s;
      wvalid_r    <= wvalid_s;
      bready_r    <= bready_s;
      arvalid_r   <= arvalid_s;
      rready_r    <= rready_s;
      awaddr_r    <= awaddr_s;
      wdata_r     <= wdata_s;
      wstrb_r     <= wstrb_s;
      araddr_r    <= araddr_s;
      rsp_valid_r <= rsp_valid_s;
      rsp_write_r <= rsp_write_s;
      rsp_rdata_r <= rsp_rdata_s;
      rsp_err_r   <= rsp_err_s;
      wdog_r      <= wdog_s;
    end
  end

  // Next-state and next-output logic; everything holds unless a branch says otherwise.
  always_comb begin
    state_s     = state_r;
    awvalid_s   = awvalid_r;
    wvalid_s    = wvalid_r;
    bready_s    = bready_r;
    arvalid_s   = arvalid_r;
    rready_s    = rready_r;
    awaddr_s    = awaddr_r;
    wdata_s     = wdata_r;
    wstrb_s     = wstrb_r;
    araddr_s    = araddr_r;
    rsp_valid_s = rsp_valid_r;
    rsp_write_s = rsp_write_r;
    rsp_rdata_s = rsp_rdata_r;
    rsp_err_s   = rsp_err_r;
    wdog_s      = wdog_r;

    case (state_r)
      ST_IDLE: begin
        if (cmd_valid) begin
          wdog_s = '0;
          if (cmd_write) begin
            state_s   = ST_WR;
            awvalid_s = 1'b1;
            wvalid_s  = 1'b1;
            bready_s  = 1'b1;
            awaddr_s  = cmd_addr;
            wdata_s   = cmd_wdata;
            wstrb_s   = cmd_wstrb;
          end else begin
            state_s   = ST_RD;
            arvalid_s = 1'b1;
            rready_s  = 1'b1;
            araddr_s  = cmd_addr;
          end
        end else begin
          state_s = ST_IDLE;
        end
      end

      ST_WR: begin
        wdog_s = wdog_r + CNT_W'(1);
        // A B response on the watchdog's last cycle still counts as success.
        if (b_done_s || (wdog_r == WDOG_LAST)) begin
          state_s     = ST_RSP;
          rsp_valid_s = 1'b1;
          rsp_write_s = 1'b1;
          rsp_err_s   = ~b_done_s;
          rsp_rdata_s = '0;
          awvalid_s   = 1'b0;
          wvalid_s    = 1'b0;
          bready_s    = 1'b0;
          awaddr_s    = '0;
          wdata_s     = '0;
          wstrb_s     = '0;
        end else begin
          state_s   = ST_WR;
          // AW and W retire independently; each valid drops after its own handshake.
          awvalid_s = awvalid_r & ~awready;
          wvalid_s  = wvalid_r & ~wready;
          bready_s  = 1'b1;
        end
      end

      ST_RD: begin
        wdog_s = wdog_r + CNT_W'(1);
        if (r_done_s || (wdog_r == WDOG_LAST)) begin
          state_s     = ST_RSP;
          rsp_valid_s = 1'b1;
          rsp_write_s = 1'b0;
          rsp_err_s   = ~r_done_s;
          rsp_rdata_s = r_done_s ? rdata : '0;
          arvalid_s   = 1'b0;
          rready_s    = 1'b0;
          araddr_s    = '0;
        end else begin
          state_s   = ST_RD;
          arvalid_s = arvalid_r & ~arready;
          rready_s  = 1'b1;
        end
      end

      ST_RSP: begin
        if (rsp_ready) begin
          state_s     = ST_IDLE;
          rsp_valid_s = 1'b0;
          rsp_write_s = 1'b0;
          rsp_rdata_s = '0;
          rsp_err_s   = 1'b0;
        end else begin
          state_s = ST_RSP;
        end
      end

      default: begin
        state_s     = ST_IDLE;
        awvalid_s   = 1'b0;
        wvalid_s    = 1'b0;
        bready_s    = 1'b0;
        arvalid_s   = 1'b0;
        rready_s    = 1'b0;
        rsp_valid_s = 1'b0;
        rsp_err_s   = 1'b0;
        wdog_s      = '0;
      end
    endcase
  end

  assign cmd_ready = (state_r == ST_IDLE);
  assign rsp_valid = rsp_valid_r;
  assign rsp_write = rsp_write_r;
  assign rsp_rdata = rsp_rdata_r;
  assign rsp_err   = rsp_err_r;
  assign awaddr    = awaddr_r;
  assign awlen     = 8'd0;
  assign awvalid   = awvalid_r;
  assign wdata     = wdata_r;
  assign wstrb     = wstrb_r;
  assign wvalid    = wvalid_r;
  assign bready    = bready_r;
  assign araddr    = araddr_r;
  assign arlen     = 8'd0;
  assign arvalid   = arvalid_r;
  assign rready    = rready_r;

endmodule

// File: tb/tb_axi_master.sv
// -----------------------------------------------------------------------------
// tb_axi_master
// Directed plus randomized bench for axi_master (TIMEOUT=8). A memory-backed
// responder with programmable per-channel delays stands in for the slave.
// Expected latency, error flag and read data come from a transaction-level
// model: write latency = max(aw,w delay) + b delay + 3 edges, read latency =
// ar delay + r delay + 2 edges; beyond TIMEOUT edges the transfer is aborted.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_axi_master;
  localparam int TO = 8;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        cmd_valid, cmd_ready, cmd_write;
  logic [31:0] cmd_addr, cmd_wdata;
  logic [3:0]  cmd_wstrb;
  logic        rsp_valid, rsp_ready, rsp_write, rsp_err;
  logic [31:0] rsp_rdata;
  logic [31:0] awaddr, wdata, araddr, rdata;
  logic [7:0]  awlen, arlen;
  logic [3:0]  wstrb;
  logic        awvalid, awready, wvalid, wready, bvalid, bready;
  logic        arvalid, arready, rvalid, rready;

  int errors = 0;
  int checks = 0;
  int edge_cnt = 0;

  // responder configuration (driven by the stimulus block only)
  int aw_dly, w_dly, b_dly, ar_dly, r_dly;
  bit aw_hang, ar_hang, resp_clr;
  // responder state (driven by the responder block only)
  int aw_wait, w_wait, b_wait, ar_wait, r_wait, b_hs;
  bit aw_done, w_done, b_started, r_pend;
  logic [31:0] aw_seen, wd_seen, ar_seen, r_hold;
  logic [3:0]  ws_seen;
  bit   [31:0] rmem [64];

  logic [31:0] ref_mem [logic [31:0]];
  logic [31:0] pool [4];

  axi_master #(.ADDR_W(32), .DATA_W(32), .TIMEOUT(TO)) dut (
    .clk(clk), .reset_n(reset_n),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
    .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata), .cmd_wstrb(cmd_wstrb),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_write(rsp_write),
    .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
    .awaddr(awaddr), .awlen(awlen), .awvalid(awvalid), .awready(awready),
    .wdata(wdata), .wstrb(wstrb), .wvalid(wvalid), .wready(wready),
    .bvalid(bvalid), .bready(bready),
    .araddr(araddr), .arlen(arlen), .arvalid(arvalid), .arready(arready),
    .rdata(rdata), .rvalid(rvalid), .rready(rready)
  );

  always #5 clk = ~clk;

  // Edge counter used to measure latencies in whole clock edges.
  always @(posedge clk) edge_cnt <= edge_cnt + 1;

  // Guard against a hung run.
  initial begin
    #300000;
    $display("FAIL global_timeout: observed no finish, expected finish");
    $fatal(1);
  end

  function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] d, input logic [3:0] s);
    logic [31:0] r;
    r = old;
    for (int b = 0; b < 4; b++) if (s[b]) r[8*b +: 8] = d[8*b +: 8];
    return r;
  endfunction

  function automatic logic [31:0] ref_read(input logic [31:0] a);
    return ref_mem.exists(a) ? ref_mem[a] : 32'h0;
  endfunction

  // Readies depend on delay counters; a hung channel never becomes ready.
  assign awready = awvalid && !aw_done && !aw_hang && (aw_wait >= aw_dly);
  assign wready  = wvalid && !w_done && (w_wait >= w_dly);
  assign arready = arvalid && !ar_hang && (ar_wait >= ar_dly);

  // Memory-backed responder: B issued after both AW and W, R after AR.
  always @(posedge clk) begin
    if (resp_clr) begin
      aw_wait <= 0; w_wait <= 0; b_wait <= 0; ar_wait <= 0; r_wait <= 0; b_hs <= 0;
      aw_done <= 1'b0; w_done <= 1'b0; b_started <= 1'b0; r_pend <= 1'b0;
      bvalid <= 1'b0; rvalid <= 1'b0; rdata <= 32'h0; r_hold <= 32'h0;
      aw_seen <= 32'h0; wd_seen <= 32'h0; ws_seen <= 4'h0; ar_seen <= 32'h0;
    end else begin
      if (awvalid && !awready) aw_wait <= aw_wait + 1;
      if (awvalid && awready) begin aw_done <= 1'b1; aw_seen <= awaddr; end
      if (wvalid && !wready) w_wait <= w_wait + 1;
      if (wvalid && wready) begin w_done <= 1'b1; wd_seen <= wdata; ws_seen <= wstrb; end
      if (aw_done && w_done && !b_started) begin
        if (b_wait == b_dly) begin
          bvalid <= 1'b1;
          b_started <= 1'b1;
          rmem[aw_seen[5:0]] <= merge(rmem[aw_seen[5:0]], wd_seen, ws_seen);
        end else begin
          b_wait <= b_wait + 1;
        end
      end
      if (bvalid && bready) begin bvalid <= 1'b0; b_hs <= b_hs + 1; end
      if (arvalid && !arready) ar_wait <= ar_wait + 1;
      if (rvalid && rready) rvalid <= 1'b0;
      if (arvalid && arready) begin
        ar_seen <= araddr;
        if (r_dly == 0) begin
          rvalid <= 1'b1;
          rdata <= rmem[araddr[5:0]];
        end else begin
          r_pend <= 1'b1;
          r_wait <= 1;
          r_hold <= rmem[araddr[5:0]];
        end
      end
      if (r_pend) begin
        if (r_wait == r_dly) begin
          rvalid <= 1'b1;
          rdata <= r_hold;
          r_pend <= 1'b0;
        end else begin
          r_wait <= r_wait + 1;
        end
      end
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic chk1(input string tag, input logic obs, input logic exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0b expected %0b", tag, obs, exp);
    end
  endtask

  task automatic cfg(input int awd, input int wd, input int bd, input int ard, input int rd,
                     input bit awh, input bit arh);
    aw_dly = awd; w_dly = wd; b_dly = bd; ar_dly = ard; r_dly = rd;
    aw_hang = awh; ar_hang = arh;
    resp_clr = 1'b1;
    @(negedge clk);
    resp_clr = 1'b0;
  endtask

  // Present a command, wait (bounded) for acceptance, then scramble the fields.
  task automatic issue(input bit wr, input logic [31:0] addr, input logic [31:0] data,
                       input logic [3:0] strb, output int acc);
    int n;
    n = 0;
    cmd_valid = 1'b1; cmd_write = wr; cmd_addr = addr; cmd_wdata = data; cmd_wstrb = strb;
    while (!cmd_ready && n < 20) begin @(negedge clk); n++; end
    chk1("cmd_ready_wait", cmd_ready, 1'b1);
    acc = edge_cnt + 1;
    @(negedge clk);
    cmd_valid = 1'b0;
    cmd_write = 1'($urandom());
    cmd_addr  = $urandom();
    cmd_wdata = $urandom();
    cmd_wstrb = 4'($urandom());
  endtask

  task automatic run_txn(input bit wr, input logic [31:0] addr, input logic [31:0] data,
                         input logic [3:0] strb, input int awd, input int wd, input int bd,
                         input int ard, input int rd, input bit hang, input int hold,
                         input bit hot);
    int acc, lat, exp_lat, n, aw_c, w_c, ar_c, mx;
    bit exp_err, split;
    logic [31:0] exp_rd, h_rd;
    logic h_w, h_e;

    if (hang) begin
      exp_err = 1'b1;
      exp_lat = TO;
    end else begin
      mx = (awd > wd) ? awd : wd;
      lat = wr ? (mx + bd + 3) : (ard + rd + 2);
      exp_err = (lat > TO);
      exp_lat = exp_err ? TO : lat;
    end
    exp_rd = (wr || exp_err) ? 32'h0 : ref_read(addr);

    cfg(awd, wd, bd, ard, rd, wr && hang, !wr && hang);
    issue(wr, addr, data, strb, acc);

    if (wr) begin
      chk("first_aw_w_b", {29'd0, awvalid, wvalid, bready}, 32'h7);
      chk("awaddr", awaddr, addr);
      chk("wdata", wdata, data);
      chk("wstrb", {28'd0, wstrb}, {28'd0, strb});
    end else begin
      chk("first_ar_r", {30'd0, arvalid, rready}, 32'h3);
      chk("araddr", araddr, addr);
    end

    n = 0; aw_c = 0; w_c = 0; ar_c = 0; split = 1'b0;
    while (!rsp_valid && n < 40) begin
      if (awvalid) aw_c++;
      if (wvalid)  w_c++;
      if (arvalid) ar_c++;
      if (awvalid && !wvalid) split = 1'b1;
      @(negedge clk);
      n++;
    end
    if (!rsp_valid) begin
      chk1("rsp_valid_wait", rsp_valid, 1'b1);
      return;
    end

    chk("latency", 32'(edge_cnt - acc), 32'(exp_lat));
    chk1("rsp_write", rsp_write, wr);
    chk1("rsp_err", rsp_err, exp_err);
    chk("rsp_rdata", rsp_rdata, exp_rd);
    chk("rsp_axi_quiet", {27'd0, awvalid, wvalid, bready, arvalid, rready}, 32'd0);
    if (!exp_err) begin
      if (wr) begin
        chk("aw_cycles", 32'(aw_c), 32'(awd + 1));
        chk("w_cycles", 32'(w_c), 32'(wd + 1));
        chk("b_handshakes", 32'(b_hs), 32'd1);
        chk("slave_awaddr", aw_seen, addr);
        chk("slave_wdata", wd_seen, data);
        if (awd > wd) chk1("w_retires_first", split, 1'b1);
        ref_mem[addr] = merge(ref_read(addr), data, strb);
      end else begin
        chk("ar_cycles", 32'(ar_c), 32'(ard + 1));
        chk("slave_araddr", ar_seen, addr);
      end
    end

    h_rd = rsp_rdata; h_w = rsp_write; h_e = rsp_err;
    if (hot) begin
      cmd_valid = 1'b1; cmd_write = 1'b0; cmd_addr = addr;
    end
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      chk("hold_stable", {rsp_rdata}, h_rd);
      chk("hold_flags", {29'd0, rsp_valid, rsp_write, rsp_err}, {29'd0, 1'b1, h_w, h_e});
      chk1("hold_cmd_ready", cmd_ready, 1'b0);
    end
    rsp_ready = 1'b1;
    @(negedge clk);
    rsp_ready = 1'b0;
    chk1("rsp_consumed", rsp_valid, 1'b0);
    chk1("idle_cmd_ready", cmd_ready, 1'b1);

    if (hot) begin
      // The waiting read must be taken on the very next edge.
      @(negedge clk);
      cmd_valid = 1'b0;
      chk("hot_accept", {30'd0, arvalid, cmd_ready}, 32'h2);
      n = 0;
      while (!rsp_valid && n < 40) begin @(negedge clk); n++; end
      chk1("hot_rsp_valid", rsp_valid, 1'b1);
      chk("hot_rdata", rsp_rdata, ref_read(addr));
      chk1("hot_rsp_write", rsp_write, 1'b0);
      rsp_ready = 1'b1;
      @(negedge clk);
      rsp_ready = 1'b0;
    end
  endtask

  initial begin
    int acc, awd, wd, bd, ard, rd, hold, pi;
    bit wr, hang;
    reset_n = 1'b0; cmd_valid = 1'b0; cmd_write = 1'b0; cmd_addr = 32'h0;
    cmd_wdata = 32'h0; cmd_wstrb = 4'h0; rsp_ready = 1'b0; resp_clr = 1'b1;
    aw_dly = 0; w_dly = 0; b_dly = 0; ar_dly = 0; r_dly = 0; aw_hang = 1'b0; ar_hang = 1'b0;
    pool[0] = 32'h10;
    for (int i = 1; i < 4; i++) pool[i] = ($urandom() & 32'hFFFF_FFC0) | 32'(i * 7 + 16);

    repeat (3) @(negedge clk);
    chk1("rst_cmd_ready", cmd_ready, 1'b1);
    chk("rst_outputs", {26'd0, rsp_valid, awvalid, wvalid, bready, arvalid, rready}, 32'd0);
    chk("rst_len", {16'd0, awlen, arlen}, 32'd0);
    reset_n = 1'b1;
    resp_clr = 1'b0;
    @(negedge clk);

    // basic write, read-back, watchdog abort, held response with queued command
    run_txn(1'b1, 32'h10, 32'hDEADBEEF, 4'hF, 0, 0, 0, 0, 0, 1'b0, 0, 1'b0);
    run_txn(1'b0, 32'h10, 32'h0, 4'h0, 0, 0, 0, 0, 0, 1'b0, 0, 1'b0);
    run_txn(1'b1, 32'h44, 32'h12345678, 4'hF, 0, 0, 0, 0, 0, 1'b1, 0, 1'b0);
    run_txn(1'b1, 32'h10, 32'hCAFE0000, 4'hC, 0, 0, 0, 0, 0, 1'b0, 5, 1'b1);
    // delayed AW with immediate W
    run_txn(1'b1, pool[1], 32'hA5A55A5A, 4'h5, 3, 0, 0, 0, 0, 1'b0, 0, 1'b0);
    // watchdog boundary: completion on the last cycle wins, one cycle later aborts
    run_txn(1'b0, 32'h10, 32'h0, 4'h0, 0, 0, 0, 3, 3, 1'b0, 0, 1'b0);
    run_txn(1'b0, 32'h10, 32'h0, 4'h0, 0, 0, 0, 4, 3, 1'b0, 0, 1'b0);
    run_txn(1'b1, pool[2], 32'h0BADF00D, 4'hF, 2, 1, 3, 0, 0, 1'b0, 0, 1'b0);
    run_txn(1'b0, pool[2], 32'h0, 4'h0, 1, 0, 0, 0, 1, 1'b0, 0, 1'b0);

    // randomized traffic over a small unaligned address pool
    for (int t = 0; t < 24; t++) begin
      wr   = 1'($urandom());
      pi   = int'($urandom_range(3, 0));
      awd  = int'($urandom_range(2, 0)); wd = int'($urandom_range(2, 0));
      bd   = int'($urandom_range(2, 0)); ard = int'($urandom_range(2, 0));
      rd   = int'($urandom_range(2, 0)); hold = int'($urandom_range(2, 0));
      hang = ($urandom_range(4, 0) == 0);
      run_txn(wr, pool[pi], $urandom(), 4'($urandom()), awd, wd, bd, ard, rd, hang, hold, 1'b0);
    end

    // reset in the middle of a write
    cfg(0, 0, 0, 0, 0, 1'b1, 1'b0);
    issue(1'b1, 32'h20, 32'h11112222, 4'hF, acc);
    chk1("mid_wr_awvalid", awvalid, 1'b1);
    #2 reset_n = 1'b0;
    #1;
    chk("async_rst_ctl", {24'd0, awvalid, wvalid, bready, arvalid, rready, rsp_valid, rsp_err, rsp_write}, 32'd0);
    chk("async_rst_awaddr", awaddr, 32'h0);
    chk("async_rst_wdata", wdata, 32'h0);
    @(negedge clk);
    reset_n = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("post_rst_idle", {30'd0, cmd_ready, rsp_valid}, 32'h2);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
